// File: rtl/matmul_seq.sv
// Sequential matrix multiplier: C = A x B through a single shared multiply-accumulate,
// one product per cycle, results written row-major into a registered C.
module matmul_seq #(
    parameter int bitlength = 8,
    parameter int M1_D1     = 3,
    parameter int M1_D2     = 3,
    parameter int M2_D2     = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [M1_D1*M1_D2*bitlength-1:0]    AI,
    input  logic [M1_D2*M2_D2*bitlength-1:0]    BI,
    output logic                                busy,
    output logic                                done,
    output logic [M1_D1*M2_D2*bitlength-1:0]    CO
);
    localparam int NA    = M1_D1 * M1_D2;
    localparam int NB    = M1_D2 * M2_D2;
    localparam int NC    = M1_D1 * M2_D2;
    localparam int IW    = (M1_D1 > 1) ? $clog2(M1_D1) : 1;
    localparam int JW    = (M2_D2 > 1) ? $clog2(M2_D2) : 1;
    localparam int KW    = (M1_D2 > 1) ? $clog2(M1_D2) : 1;
    localparam int AXW   = (NA > 1) ? $clog2(NA) : 1;
    localparam int BXW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int CXW   = (NC > 1) ? $clog2(NC) : 1;
    // one spare bit on top of the minimum so a full dot product can never wrap
    localparam int ACC_W = 2*bitlength + $clog2(M1_D2) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t                        state, state_n;
    logic [NA-1:0][bitlength-1:0]  a_q;
    logic [NB-1:0][bitlength-1:0]  b_q;
    logic [NC-1:0][bitlength-1:0]  c_q;
    logic [IW-1:0]                 i;
    logic [JW-1:0]                 j;
    logic [KW-1:0]                 k;
    logic [ACC_W-1:0]              acc, acc_next;
    logic [2*bitlength-1:0]        prod;
    logic [AXW-1:0]                a_idx;
    logic [BXW-1:0]                b_idx;
    logic [CXW-1:0]                c_idx;
    logic                          i_last, j_last, k_last;

    assign i_last = (i == IW'(M1_D1-1));
    assign j_last = (j == JW'(M2_D2-1));
    assign k_last = (k == KW'(M1_D2-1));
    assign CO     = c_q;

    always_comb begin
        a_idx    = AXW'(int'(i)*M1_D2 + int'(k));
        b_idx    = BXW'(int'(k)*M2_D2 + int'(j));
        c_idx    = CXW'(int'(i)*M2_D2 + int'(j));
        prod     = {{bitlength{1'b0}}, a_q[a_idx]} * {{bitlength{1'b0}}, b_q[b_idx]};
        acc_next = acc + {{(ACC_W-2*bitlength){1'b0}}, prod};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: if (start) state_n = ST_CALC;
            ST_CALC: begin
                busy = 1'b1;
                if (i_last && j_last && k_last) state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
            acc <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    a_q <= AI;
                    b_q <= BI;
                    c_q <= '0;
                    i   <= '0;
                    j   <= '0;
                    k   <= '0;
                    acc <= '0;
                end
                ST_CALC: begin
                    if (k_last) begin
                        // dot product complete: retire C[i][j], step to next output
                        c_q[c_idx] <= acc_next[bitlength-1:0];
                        acc        <= '0;
                        k          <= '0;
                        if (j_last) begin
                            j <= '0;
                            i <= i_last ? '0 : i + IW'(1);
                        end else begin
                            j <= j + JW'(1);
                        end
                    end else begin
                        k   <= k + KW'(1);
                        acc <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: a 4x2x3 instance and a 1x2x1 instance, directed and random runs
// checked against a plain-arithmetic matrix product.
module tb_matmul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, start_s;
    logic [63:0] AI;
    logic [47:0] BI;
    logic [15:0] AI_s, BI_s;
    logic        busy, done, busy_s, done_s;
    logic [95:0] CO;
    logic [7:0]  CO_s;
    int          total  = 0;
    int          passed = 0;

    localparam logic [63:0] A_DIR = {8'd14, 8'd13, 8'd11, 8'd10, 8'd8, 8'd7, 8'd5, 8'd4};
    localparam logic [47:0] B_DIR = {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [95:0] C_DIR = {8'd231, 8'd204, 8'd177, 8'd180, 8'd159, 8'd138,
                                     8'd129, 8'd114, 8'd99, 8'd78, 8'd69, 8'd60};

    matmul_seq #(.bitlength(8), .M1_D1(4), .M1_D2(2), .M2_D2(3)) dut (
        .clk(clk), .rst(rst), .start(start), .AI(AI), .BI(BI),
        .busy(busy), .done(done), .CO(CO));

    matmul_seq #(.bitlength(8), .M1_D1(1), .M1_D2(2), .M2_D2(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .AI(AI_s), .BI(BI_s),
        .busy(busy_s), .done(done_s), .CO(CO_s));

    always #5 clk = ~clk;

    function automatic logic [95:0] ref_mm(input logic [63:0] a, input logic [47:0] b);
        logic [95:0] c;
        c = '0;
        for (int r = 0; r < 4; r++)
            for (int col = 0; col < 3; col++) begin
                int s;
                s = 0;
                for (int x = 0; x < 2; x++)
                    s += a[(r*2+x)*8 +: 8] * b[(x*3+col)*8 +: 8];
                c[(r*3+col)*8 +: 8] = 8'(s);
            end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Starts a run on the 4x2x3 instance and follows it to the done cycle.
    task automatic run_big(input string tag, input logic [63:0] a, input logic [47:0] b,
                           input logic [95:0] exp, input bit zero_ai, input bit hold);
        int n;
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done}, 2'b00);
        AI = a; BI = b; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (zero_ai) AI = '0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 1) chk({tag, "_co_clear"}, CO, 96'd0);
            if (n == 3) chk({tag, "_co_partial"}, CO, exp & 96'hFF);
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, 24);
        chk({tag, "_done"}, {busy, done}, 2'b01);
        chk({tag, "_co"}, CO, exp);
    endtask

    task automatic run_small(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [7:0] exp);
        int n;
        @(negedge clk);
        AI_s = a; BI_s = b; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (busy_s === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, 2);
        chk({tag, "_done"}, {busy_s, done_s}, 2'b01);
        chk({tag, "_co"}, CO_s, exp);
    endtask

    initial begin
        logic [63:0] ra;
        logic [47:0] rb;
        logic [95:0] held;
        logic [15:0] sa, sb;
        int          saw_done;

        start = 1'b0; start_s = 1'b0;
        AI = '0; BI = '0; AI_s = '0; BI_s = '0;

        // asynchronous reset, asserted away from any clock edge
        #2 rst = 1'b1;
        #1 chk("reset_big", {busy, done, CO}, 98'd0);
        chk("reset_small", {busy_s, done_s, CO_s}, 10'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_big("dir", A_DIR, B_DIR, C_DIR, 1'b0, 1'b0);
        run_big("capture", A_DIR, B_DIR, C_DIR, 1'b1, 1'b0);

        // inputs change and start stays low: result must hold
        held = CO;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            AI = {$urandom, $urandom};
            BI = {16'($urandom), $urandom};
        end
        chk("idle_hold_co", CO, held);
        chk("idle_hold_ctl", {busy, done}, 2'b00);

        // start held high across back-to-back runs
        for (int r = 0; r < 3; r++) begin
            ra = {$urandom, $urandom};
            rb = {16'($urandom), $urandom};
            run_big($sformatf("hold%0d", r), ra, rb, ref_mm(ra, rb), 1'b0, r < 2);
        end

        // reset at busy cycle 10
        @(negedge clk);
        AI = A_DIR; BI = B_DIR; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", busy, 1'b1);
        rst = 1'b1;
        #1 chk("abort", {busy, done, CO}, 98'd0);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("start_in_reset", {busy, done}, 2'b00);
        rst = 1'b0;
        start = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done++;
        end
        chk("no_done_after_abort", saw_done, 0);
        run_big("after_rst", A_DIR, B_DIR, C_DIR, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            ra = {$urandom, $urandom};
            rb = {16'($urandom), $urandom};
            run_big($sformatf("rand%0d", r), ra, rb, ref_mm(ra, rb), 1'b0, 1'b0);
        end

        run_small("small_dir", {8'd100, 8'd200}, {8'd1, 8'd2}, 8'd244);
        for (int r = 0; r < 3; r++) begin
            sa = 16'($urandom);
            sb = 16'($urandom);
            run_small($sformatf("small%0d", r), sa, sb,
                      8'((sa[7:0]*sb[7:0] + sa[15:8]*sb[15:8]) % 256));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
